// File: rtl/dm_write_tracer.sv
// Store-trace FIFO: captures core data-memory writes as (address, data) pairs
// and hands them to the coprocessor one at a time over a four-phase PIO handshake.
module dm_write_tracer #(
    parameter int N     = 64,
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          DM_writeEnable,
    input  logic [N-1:0]  DM_addr,
    input  logic [N-1:0]  DM_writeData,
    input  logic          trace_enable,
    input  logic          trace_clear,
    input  logic          pop_req,
    output logic          pop_ack,
    output logic [N-1:0]  rd_addr,
    output logic [N-1:0]  rd_data,
    output logic          rd_empty,
    output logic [CW-1:0] count,
    output logic          overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    logic [2*N-1:0] r_mem [DEPTH];
    logic [AW-1:0]  r_wptr;
    logic [AW-1:0]  r_rptr;
    logic [CW-1:0]  r_count;
    logic           r_overflow;
    logic           r_pop_ack;
    logic [N-1:0]   r_rd_addr;
    logic [N-1:0]   r_rd_data;
    logic           r_rd_empty;
    state_t         r_state;
    state_t         w_state_nxt;
    logic           w_ack_nxt;
    logic           w_take;

    logic w_store;
    logic w_full;
    logic w_empty;
    logic w_cap;
    logic w_drop;
    logic w_pop;

    assign w_store = DM_writeEnable & trace_enable & ~trace_clear;
    assign w_full  = (r_count == CNT_FULL);
    assign w_empty = (r_count == {CW{1'b0}});
    assign w_cap   = w_store & ~w_full;
    assign w_drop  = w_store & w_full;
    // A pop in a clearing cycle is answered as empty; the FIFO is being flushed.
    assign w_pop   = w_take & ~w_empty & ~trace_clear;

    // Handshake state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Handshake next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (pop_req) w_state_nxt = ST_ACK;
                else         w_state_nxt = ST_IDLE;
            end
            ST_ACK: begin
                if (!pop_req) w_state_nxt = ST_IDLE;
                else          w_state_nxt = ST_ACK;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Handshake output decode: pop acceptance and next acknowledge level
    always_comb begin
        w_take    = 1'b0;
        w_ack_nxt = r_pop_ack;
        case (r_state)
            ST_IDLE: begin
                if (pop_req) begin
                    w_take    = 1'b1;
                    w_ack_nxt = 1'b1;
                end else begin
                    w_take    = 1'b0;
                    w_ack_nxt = r_pop_ack;
                end
            end
            ST_ACK: begin
                if (!pop_req) w_ack_nxt = 1'b0;
                else          w_ack_nxt = r_pop_ack;
            end
            default: begin
                w_take    = 1'b0;
                w_ack_nxt = 1'b0;
            end
        endcase
    end

    // Storage array; deliberately left unreset
    always_ff @(posedge clk) begin
        if (w_cap) begin
            r_mem[r_wptr] <= {DM_addr, DM_writeData};
        end
    end

    // Pointers, occupancy and sticky overflow
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr     <= {AW{1'b0}};
            r_rptr     <= {AW{1'b0}};
            r_count    <= {CW{1'b0}};
            r_overflow <= 1'b0;
        end else if (trace_clear) begin
            r_wptr     <= {AW{1'b0}};
            r_rptr     <= {AW{1'b0}};
            r_count    <= {CW{1'b0}};
            r_overflow <= 1'b0;
        end else begin
            if (w_cap) r_wptr <= r_wptr + PTR_ONE;
            if (w_pop) r_rptr <= r_rptr + PTR_ONE;
            case ({w_cap, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    // Registered pop results and acknowledge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pop_ack  <= 1'b0;
            r_rd_addr  <= {N{1'b0}};
            r_rd_data  <= {N{1'b0}};
            r_rd_empty <= 1'b1;
        end else begin
            r_pop_ack <= w_ack_nxt;
            if (w_pop) begin
                {r_rd_addr, r_rd_data} <= r_mem[r_rptr];
                r_rd_empty             <= 1'b0;
            end else if (w_take) begin
                r_rd_empty <= 1'b1;
            end
        end
    end

    assign pop_ack  = r_pop_ack;
    assign rd_addr  = r_rd_addr;
    assign rd_data  = r_rd_data;
    assign rd_empty = r_rd_empty;
    assign count    = r_count;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_dm_write_tracer.sv
// Randomized and directed bench for dm_write_tracer, checked against a
// queue-based model of the store stream and the pop handshake.
module tb_dm_write_tracer;

    localparam int N     = 64;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          DM_writeEnable = 1'b0;
    logic [N-1:0]  DM_addr = '0;
    logic [N-1:0]  DM_writeData = '0;
    logic          trace_enable = 1'b0;
    logic          trace_clear = 1'b0;
    logic          pop_req = 1'b0;
    logic          pop_ack;
    logic [N-1:0]  rd_addr;
    logic [N-1:0]  rd_data;
    logic          rd_empty;
    logic [CW-1:0] count;
    logic          overflow;

    dm_write_tracer #(.N(N), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .DM_writeEnable(DM_writeEnable), .DM_addr(DM_addr), .DM_writeData(DM_writeData),
        .trace_enable(trace_enable), .trace_clear(trace_clear),
        .pop_req(pop_req), .pop_ack(pop_ack),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_empty(rd_empty),
        .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: the FIFO contents as a queue plus the coprocessor-visible view
    logic [2*N-1:0] m_q[$];
    logic           m_ovf   = 1'b0;
    logic           m_ack   = 1'b0;
    logic           m_empty = 1'b1;
    logic [N-1:0]   m_addr  = '0;
    logic [N-1:0]   m_data  = '0;

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ovf   = 1'b0;
        m_ack   = 1'b0;
        m_empty = 1'b1;
        m_addr  = '0;
        m_data  = '0;
    endtask

    task automatic model_step();
        int pre;
        pre = m_q.size();
        if (!m_ack && pop_req) begin
            m_ack = 1'b1;
            if (trace_clear || pre == 0) begin
                m_empty = 1'b1;
            end else begin
                {m_addr, m_data} = m_q.pop_front();
                m_empty = 1'b0;
            end
        end else if (m_ack && !pop_req) begin
            m_ack = 1'b0;
        end
        if (trace_clear) begin
            m_q.delete();
            m_ovf = 1'b0;
        end else if (DM_writeEnable && trace_enable) begin
            if (pre < DEPTH) m_q.push_back({DM_addr, DM_writeData});
            else             m_ovf = 1'b1;
        end
    endtask

    task automatic check_all();
        chk("count",    N'(count),    N'(m_q.size()));
        chk("overflow", N'(overflow), N'(m_ovf));
        chk("pop_ack",  N'(pop_ack),  N'(m_ack));
        chk("rd_empty", N'(rd_empty), N'(m_empty));
        chk("rd_addr",  rd_addr,      m_addr);
        chk("rd_data",  rd_data,      m_data);
    endtask

    task automatic cyc(input logic we, input logic [N-1:0] a, input logic [N-1:0] d,
                       input logic en, input logic clr, input logic req);
        DM_writeEnable = we;
        DM_addr        = a;
        DM_writeData   = d;
        trace_enable   = en;
        trace_clear    = clr;
        pop_req        = req;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle_cyc(input logic req);
        cyc(1'b0, '0, '0, 1'b1, 1'b0, req);
    endtask

    logic [N-1:0] ord_a [3];
    logic [N-1:0] ord_d [3];

    initial begin
        ord_a = '{64'h0, 64'h8, 64'h10};
        ord_d = '{64'h11, 64'h22, 64'h33};

        // Reset state
        #12;
        chk("rst_count", N'(count), 64'd0);
        chk("rst_empty", N'(rd_empty), 64'd1);
        chk("rst_ack", N'(pop_ack), 64'd0);
        chk("rst_addr", rd_addr, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Pop on an empty FIFO
        idle_cyc(1'b1);
        chk("empty_pop_ack", N'(pop_ack), 64'd1);
        chk("empty_pop_flag", N'(rd_empty), 64'd1);
        idle_cyc(1'b0);
        chk("empty_pop_release", N'(pop_ack), 64'd0);

        // Ordering
        for (int i = 0; i < 3; i++) cyc(1'b1, ord_a[i], ord_d[i], 1'b1, 1'b0, 1'b0);
        chk("ord_count", N'(count), 64'd3);
        for (int i = 0; i < 3; i++) begin
            idle_cyc(1'b1);
            chk("ord_addr", rd_addr, ord_a[i]);
            chk("ord_data", rd_data, ord_d[i]);
            chk("ord_empty", N'(rd_empty), 64'd0);
            idle_cyc(1'b0);
        end
        chk("ord_final_count", N'(count), 64'd0);

        // Overflow: DEPTH+2 stores, only the first DEPTH kept
        for (int i = 1; i <= DEPTH + 2; i++) begin
            cyc(1'b1, N'(i), N'(i + 1000), 1'b1, 1'b0, 1'b0);
            chk("ovf_flag", N'(overflow), (i > DEPTH) ? 64'd1 : 64'd0);
        end
        chk("ovf_count", N'(count), N'(DEPTH));
        for (int i = 1; i <= DEPTH; i++) begin
            idle_cyc(1'b1);
            chk("ovf_pop_addr", rd_addr, N'(i));
            idle_cyc(1'b0);
        end
        idle_cyc(1'b1);
        chk("ovf_drained", N'(rd_empty), 64'd1);
        idle_cyc(1'b0);
        cyc(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);

        // Wrap with simultaneous store and pop
        for (int i = 0; i < 3; i++) cyc(1'b1, N'(200 + i), N'(i), 1'b1, 1'b0, 1'b0);
        for (int j = 0; j < 40; j++) begin
            cyc((j % 2) == 0, N'(300 + j), N'(j), 1'b1, 1'b0, (j % 2) == 0);
            chk("wrap_count", N'(count), 64'd3);
        end
        for (int i = 0; i < 3; i++) begin
            idle_cyc(1'b1);
            idle_cyc(1'b0);
        end
        chk("wrap_drained", N'(count), 64'd0);

        // Gating and clear
        for (int i = 0; i < 4; i++) cyc(1'b1, N'(i), N'(i), 1'b0, 1'b0, 1'b0);
        chk("gate_count", N'(count), 64'd0);
        for (int i = 0; i < 5; i++) cyc(1'b1, N'(i), N'(i), 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 64'hABC, 64'hDEF, 1'b1, 1'b1, 1'b0);
        chk("clr_count", N'(count), 64'd0);
        chk("clr_ovf", N'(overflow), 64'd0);
        idle_cyc(1'b1);
        chk("clr_pop_empty", N'(rd_empty), 64'd1);
        idle_cyc(1'b0);

        // Asynchronous reset in the ACK phase
        for (int i = 0; i < 2; i++) cyc(1'b1, N'(50 + i), N'(i), 1'b1, 1'b0, 1'b0);
        idle_cyc(1'b1);
        chk("ar_ack_before", N'(pop_ack), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("ar_ack", N'(pop_ack), 64'd0);
        chk("ar_count", N'(count), 64'd0);
        model_reset();
        #1 reset_n = 1'b1;
        idle_cyc(1'b0);
        idle_cyc(1'b1);
        chk("ar_repop_empty", N'(rd_empty), 64'd1);
        chk("ar_repop_addr", rd_addr, 64'd0);
        idle_cyc(1'b0);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            cyc(($urandom % 2) == 0, {$urandom, $urandom}, {$urandom, $urandom},
                ($urandom % 5) != 0, ($urandom % 40) == 0, ($urandom % 3) != 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
